serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b, one bit per clock, LSB first.
- Companion to the combinational half-adder cell: same bit-level XOR/AND style, in the subtract direction, with borrow in place of carry.
- Intended for area-constrained datapaths where a ripple subtractor is too large.
- Uses a start/busy/done handshake and is driven by a local controller.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  one-cycle pulse when diff/borrow are updated.
- diff  output  WIDTH  result a - b modulo 2^WIDTH.
- borrow  output  1  final borrow out; 1 iff a < b unsigned.

Behaviour:
- One clock domain; reset is synchronous and active-high (rst sampled on rising clk).
- Reset values: busy=0, done=0, diff=0, borrow=0, state=IDLE, bit counter=0, internal shift registers=0.
- States:
  - IDLE: busy=0. start=1 -> load a_sh=a, b_sh=b, bin=0, cnt=0, go to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - d = a_sh[0] ^ b_sh[0] ^ bin
    - bout = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bin)
    - d shifts into the MSB of the result shift register; a_sh and b_sh shift right; bin <= bout; cnt++.
    - After the cycle with cnt == WIDTH-1, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. diff and borrow are registered on entry to DONE. start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start accepted at edge N -> done=1 and diff/borrow valid during cycle N+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- diff/borrow hold their value until the next DONE. They are not cleared by start, only by rst.
- start during SHIFT is ignored: no restart, no queueing. a/b changes during SHIFT have no effect.
- Borrow chain is unsigned. a == b gives diff=0, borrow=0. a=0, b=2^WIDTH-1 gives diff=1, borrow=1.
- Counter width is clog2(WIDTH) bits. It does not wrap mid-operation and is cleared on accepted start.
- rst mid-operation aborts immediately: all registers return to reset values next edge, and no done pulse is produced.
- rst and start high in the same cycle: rst wins.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), signed two's-complement overflow.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using captured operands.
  - Registered together with diff and held the same way; reset value 0.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, start with a=0x05, b=0x03 -> busy high 8 cycles, done pulse at cycle 9 after start, diff=0x02, borrow=0, ovf=0.
- a=0x03, b=0x05 -> diff=0xFE, borrow=1. a=0x00, b=0xFF -> diff=0x01, borrow=1.
- a=0x80, b=0x01 -> diff=0x7F, borrow=0; ovf=1 with SERIAL_SUB_OVF_EN.
- start pulsed with a=0x10, b=0x01; at cycle 3 pulse start again with a=0xFF, b=0xFF -> single done, diff=0x0F. Then start in the DONE cycle with a=0xFF, b=0xFF -> second done exactly 9 cycles later, diff=0x00.
- rst asserted at cycle 4 of an operation -> next cycle busy=0, diff=0, borrow=0, no done pulse. A new start afterwards completes normally.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with start/busy/done handshake.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             d_bit, bout;
`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are kept because a_sh/b_sh lose them while shifting.
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    d_bit = a_sh_q[0] ^ b_sh_q[0] ^ bin_q;
    bout  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bin_q);

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        bin_d  = bout;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d  = DONE;
          diff_d   = {d_bit, res_q[WIDTH-1:1]};
          borrow_d = bout;
`ifdef SERIAL_SUB_OVF_EN
          // The final d_bit is the result sign bit.
          ovf_d    = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed vectors queue expected results,
// a monitor pops and checks them on every done pulse.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, borrow;
  logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got done=1 with diff=0x%0h, expected no result", diff);
      end else begin
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e.diff));
        check("borrow", 32'(borrow), 32'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Drive start for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic push, input logic [WIDTH-1:0] ed,
                       input logic eb, input logic eo);
    exp_t e;
    start = 1'b1;
    a = av;
    b = bv;
    if (push) begin
      e.diff = ed; e.borrow = eb; e.ovf = eo;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts negedges until done, also verifying busy stays high before it.
  task automatic wait_done(input string name);
    int cyc = 0;
    int busy_bad = 0;
    while (cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (done) break;
      if (busy !== 1'b1) busy_bad++;
    end
    check({name, "_latency"}, 32'(cyc), 32'(WIDTH + 1));
    check({name, "_busy_low"}, 32'(busy_bad), 32'd0);
  endtask

  task automatic run(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                     input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
    issue(av, bv, 1'b1, ed, eb, eo);
    wait_done(name);
    check({name, "_busy_in_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    // rst wins over start
    start = 1'b1; a = 8'h05; b = 8'h01;
    @(posedge clk); #1;
    check("rst_vs_start_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    run("v05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    check("done_is_pulse", 32'(done), 32'd0);
    check("diff_held", 32'(diff), 32'h02);
    run("v03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run("v00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);
    run("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run("v7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    run("vaa_aa", 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0);

    // start during SHIFT is ignored, then back-to-back start in DONE
    issue(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0; a = 8'h33; b = 8'h44;
    // two negedges already consumed by the ignored-start window plus this one
    begin
      int cyc = 3;
      while (cyc < 50 && !done) begin
        @(negedge clk);
        cyc++;
      end
      check("ignore_start_latency", 32'(cyc), 32'(WIDTH + 1));
    end
    issue(8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
    wait_done("back_to_back");
    @(posedge clk); #1;

    // prime a nonzero result, then abort an operation with rst
    run("v20_30", 8'h20, 8'h30, 8'hF0, 1'b1, 1'b0);
    issue(8'h55, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (WIDTH + 4) @(posedge clk);
    #1;
    run("after_abort", 8'h55, 8'h11, 8'h44, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time bound, expected completion");
    $fatal(1, "timeout");
  end

endmodule
